// File: rtl/encoder83_pkg.sv
// Shared widths, state encodings and reset constants for the 8-to-3 request encoder.
// Optional round-robin selection is enabled with ENCODER83_ROUND_ROBIN_EN.
package encoder83_pkg;
    localparam int REQ_W = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_e;

    localparam logic [IDX_W-1:0] OUT_IDX_RST = '0;
    localparam logic [IDX_W-1:0] RR_PTR_RST  = 3'd7;

    function automatic logic [REQ_W-1:0] idx2mask(input logic [IDX_W-1:0] idx);
        return REQ_W'(1) << idx;
    endfunction
endpackage

// File: rtl/encoder83_sequencer_if.sv
// Request/issue bus of the encoder: request strobe in, valid/ready index out.
interface encoder83_sequencer_if;
    import encoder83_pkg::*;

    logic             req_valid;
    logic [REQ_W-1:0] req_in;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic [REQ_W-1:0] pending;
    logic             coalesced;

    modport master (
        output req_valid, req_in, out_ready,
        input  out_valid, out_idx, pending, coalesced
    );

    modport slave (
        input  req_valid, req_in, out_ready,
        output out_valid, out_idx, pending, coalesced
    );
endinterface

// File: rtl/encoder83_sequencer_prio_enc8.sv
// Combinational 8-way priority picker: highest index wins, or with
// ENCODER83_ROUND_ROBIN_EN the first set bit at or after start_i (wrapping).
module prio_enc8
    import encoder83_pkg::*;
(
    input  logic [REQ_W-1:0] vec_i,
    input  logic [IDX_W-1:0] start_i,
    output logic             any_o,
    output logic [IDX_W-1:0] idx_o,
    output logic [REQ_W-1:0] mask_o
);
`ifdef ENCODER83_ROUND_ROBIN_EN
    logic [IDX_W-1:0] pos;

    // Walk offsets from farthest to nearest so the nearest hit is assigned last.
    always_comb begin
        idx_o = '0;
        pos   = '0;
        for (int k = REQ_W-1; k >= 0; k--) begin
            pos = start_i + IDX_W'(k);
            if (vec_i[pos]) idx_o = pos;
        end
    end
`else
    logic unused_start;
    assign unused_start = ^start_i;

    always_comb begin
        idx_o = '0;
        for (int i = 0; i < REQ_W; i++) begin
            if (vec_i[i]) idx_o = IDX_W'(i);
        end
    end
`endif

    assign any_o  = |vec_i;
    assign mask_o = any_o ? idx2mask(idx_o) : '0;
endmodule

// File: rtl/encoder83_sequencer.sv
// Registered 8-to-3 request encoder: merges requests into pending and issues one
// index per handshake. Define ENCODER83_ROUND_ROBIN_EN for round-robin selection.
module encoder83_sequencer
    import encoder83_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    encoder83_sequencer_if.slave  bus
);
    state_e           state_q;
    logic [IDX_W-1:0] out_idx_q;
    logic [REQ_W-1:0] pending_q, pending_d;
    logic             coalesced_q, coalesced_d;

    logic             any;
    logic [IDX_W-1:0] sel_idx, start;
    logic [REQ_W-1:0] sel_onehot, sel_mask, req_bits;
    logic             load;

`ifdef ENCODER83_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q;

    assign start = ptr_q + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (rst)       ptr_q <= RR_PTR_RST;
        else if (load) ptr_q <= sel_idx;
    end
`else
    assign start = '0;
`endif

    prio_enc8 u_prio (
        .vec_i   (pending_q),
        .start_i (start),
        .any_o   (any),
        .idx_o   (sel_idx),
        .mask_o  (sel_onehot)
    );

    // Only registered pending is searched; in PRESENT a load needs the handshake.
    assign load        = any & ((state_q == ST_IDLE) | bus.out_ready);
    assign sel_mask    = load ? sel_onehot : '0;
    assign req_bits    = bus.req_valid ? bus.req_in : '0;
    assign pending_d   = (pending_q & ~sel_mask) | req_bits;
    assign coalesced_d = |(req_bits & pending_q & ~sel_mask);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_idx_q   <= OUT_IDX_RST;
            pending_q   <= '0;
            coalesced_q <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            coalesced_q <= coalesced_d;
            case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        state_q   <= ST_PRESENT;
                        out_idx_q <= sel_idx;
                    end
                end
                ST_PRESENT: begin
                    if (bus.out_ready) begin
                        if (load) out_idx_q <= sel_idx;
                        else      state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.out_valid = (state_q == ST_PRESENT);
    assign bus.out_idx   = out_idx_q;
    assign bus.pending   = pending_q;
    assign bus.coalesced = coalesced_q;
endmodule

// File: tb/tb_encoder83_sequencer.sv
// Directed scenarios plus random traffic checked against a behavioural model.
module tb_encoder83_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    encoder83_sequencer_if bus_if();

    encoder83_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

`ifdef ENCODER83_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int issued [8];

    // model state
    bit       m_valid;
    bit [2:0] m_idx;
    bit [2:0] m_ptr;
    bit [7:0] m_pend;
    bit       m_coal;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Winner among pending requests: highest index, or first after the last issued.
    function automatic int pick(input bit [7:0] p);
        int i;
        for (int k = 0; k < 8; k++) begin
            i = RR ? (int'(m_ptr) + 1 + k) % 8 : 7 - k;
            if (p[i]) return i;
        end
        return -1;
    endfunction

    task automatic clr_issued();
        for (int i = 0; i < 8; i++) issued[i] = 0;
    endtask

    task automatic drive(input bit rv, input bit [7:0] rin, input bit rdy);
        bus_if.req_valid = rv;
        bus_if.req_in    = rin;
        bus_if.out_ready = rdy;
    endtask

    task automatic cyc();
        int       s;
        bit [7:0] selbit;
        bit       ld;
        if (!rst && bus_if.out_valid && bus_if.out_ready) issued[bus_if.out_idx]++;
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_idx = 0; m_pend = 0; m_coal = 0; m_ptr = 3'd7;
        end else begin
            ld     = (m_pend != 0) && (!m_valid || bus_if.out_ready);
            s      = pick(m_pend);
            selbit = ld ? 8'(1) << s : 8'h00;
            m_coal = bus_if.req_valid && ((bus_if.req_in & m_pend & ~selbit) != 0);
            m_pend = (m_pend & ~selbit) | (bus_if.req_valid ? bus_if.req_in : 8'h00);
            if (ld) begin
                m_valid = 1; m_idx = 3'(s); m_ptr = 3'(s);
            end else if (m_valid && bus_if.out_ready) begin
                m_valid = 0;
            end
        end
        #1;
        chk("m_valid", 32'(bus_if.out_valid), 32'(m_valid));
        chk("m_idx",   32'(bus_if.out_idx),   32'(m_idx));
        chk("m_pend",  32'(bus_if.pending),   32'(m_pend));
        chk("m_coal",  32'(bus_if.coalesced), 32'(m_coal));
    endtask

    initial begin
        // reset
        rst = 1'b1;
        drive(0, 8'h00, 0);
        cyc();
        chk("rst_valid", 32'(bus_if.out_valid), 0);
        chk("rst_idx",   32'(bus_if.out_idx),   0);
        chk("rst_pend",  32'(bus_if.pending),   0);
        chk("rst_coal",  32'(bus_if.coalesced), 0);
        rst = 1'b0;

        // two-request burst
        drive(1, 8'h24, 1); cyc();
        drive(0, 8'h00, 1); cyc();
        chk("burst_first", 32'(bus_if.out_idx), RR ? 2 : 5);
        cyc();
        chk("burst_second", 32'(bus_if.out_idx), RR ? 5 : 2);
        cyc();
        chk("burst_idle", 32'(bus_if.out_valid), 0);
        chk("burst_pend", 32'(bus_if.pending), 0);

        // backpressure
        clr_issued();
        drive(1, 8'h81, 0); cyc();
        drive(0, 8'h00, 0); cyc();
        for (int k = 0; k < 4; k++) begin
            chk("bp_hold_idx",  32'(bus_if.out_idx), 7);
            chk("bp_hold_pend", 32'(bus_if.pending), 32'h01);
            cyc();
        end
        drive(0, 8'h00, 1); cyc();
        chk("bp_next_idx", 32'(bus_if.out_idx), 0);
        cyc();
        chk("bp_idle", 32'(bus_if.out_valid), 0);
        chk("bp_issued7", issued[7], 1);
        chk("bp_issued0", issued[0], 1);

        // coalesce onto pending, unselected bit 3
        clr_issued();
        drive(1, 8'h2A, 0); cyc();
        drive(0, 8'h00, 0); cyc();
        chk("co_bit3_pending", 32'(bus_if.pending[3]), 1);
        drive(1, 8'h08, 0); cyc();
        chk("co_pulse", 32'(bus_if.coalesced), 1);
        drive(0, 8'h00, 0); cyc();
        chk("co_pulse_end", 32'(bus_if.coalesced), 0);
        drive(0, 8'h00, 1);
        repeat (4) cyc();
        chk("co_idle", 32'(bus_if.out_valid), 0);
        chk("co_issued3", issued[3], 1);

        // re-request of the presented index
        clr_issued();
        drive(1, 8'h10, 0); cyc();
        drive(0, 8'h00, 0); cyc();
        chk("rr_present4", 32'(bus_if.out_idx), 4);
        drive(1, 8'h10, 0); cyc();
        chk("rr_pend", 32'(bus_if.pending), 32'h10);
        chk("rr_nocoal", 32'(bus_if.coalesced), 0);
        drive(0, 8'h00, 1);
        repeat (3) cyc();
        chk("rr_issued4", issued[4], 2);
        chk("rr_idle", 32'(bus_if.out_valid), 0);

        // reset while presenting
        drive(1, 8'hFF, 0); cyc(); cyc();
        chk("mr_pend_full", 32'(bus_if.pending), 32'hFF);
        chk("mr_valid", 32'(bus_if.out_valid), 1);
        rst = 1'b1;
        drive(1, 8'h01, 0); cyc();
        chk("mr_valid0", 32'(bus_if.out_valid), 0);
        chk("mr_pend0",  32'(bus_if.pending), 0);
        chk("mr_idx0",   32'(bus_if.out_idx), 0);
        rst = 1'b0;

        // continuous 0x81 stream
        drive(1, 8'h81, 1); cyc();
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("wrap_idx", 32'(bus_if.out_idx), RR ? ((k % 2 == 0) ? 0 : 7) : 7);
        end
        drive(0, 8'h00, 1);
        repeat (4) cyc();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            drive(1'($urandom_range(0, 1)), 8'($urandom & $urandom),
                  ($urandom_range(0, 3) != 0));
            cyc();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/encoder83_sequencer.md
# encoder83_sequencer

Registered 8-to-3 request encoder, the inverse of the 3-to-8 one-hot decoder in the select path. It accumulates one-hot or multi-hot request lines into a pending register and emits one 3-bit index per valid/ready handshake. It sits upstream of the decoder: a producer raises request bits, and a consumer takes encoded indices until pending is drained.

## Interface
- No parameters. Width is fixed at 8 requests and 3 index bits.
- `clk`  in  1  single clock; everything is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  when high, `req_in` is merged into pending this cycle.
- `req_in`  in  8  request bits; any combination is legal, including 0.
- `out_valid`  out  1  `out_idx` holds a served request.
- `out_ready`  in  1  consumer accepts `out_idx` when `out_valid & out_ready`.
- `out_idx`  out  3  encoded index of the request being presented.
- `pending`  out  8  requests not yet issued; excludes the index currently presented.
- `coalesced`  out  1  one-cycle pulse: a request arrived for a bit already pending.

## Operation
- State machine:
  - States are IDLE (`out_valid`=0) and PRESENT (`out_valid`=1).
  - IDLE → PRESENT when `pending` != 0. The selected index is loaded into `out_idx` and its bit is cleared from pending.
  - PRESENT holds `out_idx` stable while `out_ready`=0.
  - PRESENT on handshake with `pending` != 0: load the next index back-to-back and stay in PRESENT.
  - PRESENT on handshake with `pending` == 0: go to IDLE.
- Selection uses only the registered `pending` value. Same-cycle `req_in` is never selected.
- Pending update each cycle: pending_next = (pending & ~sel_mask) | (req_valid ? req_in : 0).
  - `sel_mask` is the one-hot bit of the index being loaded this cycle, or 0 if none is loaded.
  - A new request for the bit being selected in the same cycle sets it again, so it is served again later.
- A request for the index currently presented, which is already cleared from pending, sets pending normally and is not coalesced.
- `coalesced` next = req_valid & |(req_in & pending & ~sel_mask). Coalesced requests are merged and served once.
- Default priority is fixed: the highest set index wins (bit 7 > … > bit 0).
- Reset values: state IDLE, `out_valid`=0, `out_idx`=3'b000, `pending`=8'h00, `coalesced`=0, round-robin pointer=3'd7.
- `rst` mid-presentation drops the presented index and all pending requests. `req_valid` is ignored in the reset cycle.

## Timing
- `req_valid` sampled at edge N → bit in `pending` after edge N → `out_valid` after edge N+1. Minimum latency is 2 cycles.
- Sustained throughput is one index per cycle while `out_ready`=1 and pending is non-empty.
- `out_idx` and `out_valid` are registered outputs with no combinational path from `out_ready`.
- `pending` and `coalesced` are registered.

## Configuration
- Macro `ENCODER83_ROUND_ROBIN_EN`.
- Defined:
  - Round-robin selection. A 3-bit pointer holds the last issued index.
  - The search starts at pointer+1 and wraps modulo 8, so after 7 the search starts at 0.
  - The pointer updates whenever an index is loaded. Its reset value 7 makes the first search start at bit 0.
- Undefined: fixed highest-index priority, and no pointer register exists.

## Structure
- Shared package `encoder83_pkg` holds:
  - `REQ_W`=8 and `IDX_W`=3.
  - State encodings `ST_IDLE`=1'b0 and `ST_PRESENT`=1'b1.
  - The `out_idx` reset constant.
- Sub-module `prio_enc8` is combinational:
  - Inputs: 8-bit vector and 3-bit start index.
  - Outputs: `any`, 3-bit `idx`, and 8-bit one-hot `mask`.
  - It searches downward from 7 in fixed mode, or upward from start with wrap in round-robin mode.

## Test plan
- Reset, then `req_in`=8'b0010_0100 for one cycle with `out_ready`=1.
  - Fixed mode: `out_idx` = 5 then 2 on consecutive cycles.
  - Round-robin mode: `out_idx` = 2 then 5.
  - Then `out_valid`=0 and `pending`=0.
- Backpressure:
  - `req_in`=8'h81 with `out_ready`=0 for 4 cycles: `out_idx`=7 is held, `pending`=8'h01.
  - Raise `out_ready`: indices 7 then 0 are issued, then IDLE.
- Coalesce:
  - With bit 3 pending and unselected, strobe `req_in`=8'h08: `coalesced` pulses once, and index 3 is issued exactly once.
- Re-request of the presented index:
  - While `out_idx`=4 is stalled, strobe `req_in`=8'h10: `pending`=8'h10 and `coalesced`=0.
  - Index 4 is issued twice in total.
- Reset mid-operation:
  - With `pending`=8'hFF and `out_valid`=1, assert `rst` together with `req_valid`=1 and `req_in`=8'h01.
  - Next cycle: `out_valid`=0, `pending`=8'h00, `out_idx`=0.
- Round-robin wrap:
  - Keep `req_in`=8'h81 strobed continuously with `out_ready`=1.
  - `out_idx` sequence is 0, 7, 0, 7 …; fixed mode gives 7, 7, 7 ….
